// File: rtl/regfile_param_if.sv
// regfile_param_if: bus between the ID-stage decode logic (master) and the
// parametrised register file (slave).
//
// Signals:
//   RegWrite   master->slave  write enable
//   WriteReg   master->slave  write address (ADDR_W)
//   WriteData  master->slave  write data (DATA_W)
//   rd_en      master->slave  per-port read enable, bit i = port i
//   ReadReg    master->slave  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   ReadData   slave->master  packed registered read data, port i at [i*DATA_W +: DATA_W]
//   ready      slave->master  high once the post-reset clear pass has finished
//   wr_drop    slave->master  one-cycle pulse after an enabled write was discarded
//
// Protocol: there is no backpressure on individual transfers. A write
// presented with RegWrite=1 at a posedge is taken at that edge only if ready
// is high and the address is in range; otherwise it is lost and wr_drop
// reports it on the following cycle (except the silent register-0 case).
// Reads are issued by rd_en at a posedge and the data is valid on ReadData
// for the whole following cycle, held until the next enabled read.
interface regfile_param_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int ADDR_W   = $clog2(NUM_REGS)
);
  logic                       RegWrite;
  logic [ADDR_W-1:0]          WriteReg;
  logic [DATA_W-1:0]          WriteData;
  logic [NUM_RD-1:0]          rd_en;
  logic [NUM_RD*ADDR_W-1:0]   ReadReg;
  logic [NUM_RD*DATA_W-1:0]   ReadData;
  logic                       ready;
  logic                       wr_drop;

  modport master (
    output RegWrite, WriteReg, WriteData, rd_en, ReadReg,
    input  ReadData, ready, wr_drop
  );

  modport slave (
    input  RegWrite, WriteReg, WriteData, rd_en, ReadReg,
    output ReadData, ready, wr_drop
  );
endinterface

// File: rtl/regfile_param.sv
// regfile_param: parametrised integer register file for the ID stage.
// NUM_RD synchronous write-first read ports with same-cycle bypass, one write
// port, optional hardwired-zero register 0. After reset a sequencer clears
// one entry per cycle so the array itself carries no reset and can map onto
// block RAM.
//
// Ports:
//   clk      in   clock, all state changes on posedge
//   reset    in   synchronous active-low reset
//   bus      slave modport of regfile_param_if (write port, read ports,
//            ready, wr_drop)
//   state_o  out  current sequencer state (0 = INIT, 1 = RUN)
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic           clk,
  input  logic           reset,
  regfile_param_if.slave bus,
  output logic           state_o
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Address comparisons are done one bit wider so a non-power-of-two
  // NUM_REGS can be range-checked without wrap-around.
  localparam logic [ADDR_W:0]   NREGS = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < NREGS;
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  state_e                    state_q;
  logic [ADDR_W-1:0]         init_ptr_q;
  logic [NUM_RD*DATA_W-1:0]  rdata_q, rdata_d;
  logic                      ready_q;
  logic                      wr_drop_q, wr_drop_d;

  // Storage array: intentionally without reset, cleared by the INIT pass.
  logic [DATA_W-1:0]         regs_q [NUM_REGS];

  logic                      wr_in_range;
  logic                      wr_accept;
  logic                      arr_we;
  logic [ADDR_W-1:0]         arr_waddr;
  logic [DATA_W-1:0]         arr_wdata;
  logic [ADDR_W-1:0]         raddr;

  // Write-port decode. During INIT the single array write port is owned by
  // the clear sequencer, so any user write is dropped and reported.
  always_comb begin
    wr_in_range = in_range(bus.WriteReg);
    wr_accept   = (state_q == ST_RUN) && bus.RegWrite && wr_in_range &&
                  !is_zero_reg(bus.WriteReg);
    wr_drop_d   = bus.RegWrite && ((state_q == ST_INIT) || !wr_in_range);
    arr_we      = reset && ((state_q == ST_INIT) || wr_accept);
    arr_waddr   = (state_q == ST_INIT) ? init_ptr_q : bus.WriteReg;
    arr_wdata   = (state_q == ST_INIT) ? '0 : bus.WriteData;
  end

  // Read ports: priority out-of-range, zero register, bypass, array.
  always_comb begin
    rdata_d = rdata_q;
    raddr   = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      raddr = bus.ReadReg[i*ADDR_W +: ADDR_W];
      if (state_q == ST_INIT) begin
        rdata_d[i*DATA_W +: DATA_W] = '0;
      end else if (bus.rd_en[i]) begin
        if (!in_range(raddr) || is_zero_reg(raddr)) begin
          rdata_d[i*DATA_W +: DATA_W] = '0;
        end else if (wr_accept && (bus.WriteReg == raddr)) begin
          rdata_d[i*DATA_W +: DATA_W] = bus.WriteData;
        end else begin
          rdata_d[i*DATA_W +: DATA_W] = regs_q[raddr];
        end
      end
    end
  end

  // Sequencer and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      wr_drop_q  <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      wr_drop_q <= wr_drop_d;
      case (state_q)
        ST_INIT: begin
          if (init_ptr_q == LAST) begin
            state_q    <= ST_RUN;
            ready_q    <= 1'b1;
            init_ptr_q <= '0;
          end else begin
            init_ptr_q <= init_ptr_q + 1'b1;
          end
        end
        ST_RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) begin
      regs_q[arr_waddr] <= arr_wdata;
    end
  end

  assign bus.ReadData = rdata_q;
  assign bus.ready    = ready_q;
  assign bus.wr_drop  = wr_drop_q;
  assign state_o      = state_q;

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised successor to the pipeline's integer register file, in the ID stage of the MIPS pipeline. It provides NUM_RD synchronous read ports and one write port. Reads are write-first with same-cycle bypass, and register 0 is optionally hardwired to zero. After reset, a built-in sequencer clears the array one entry per cycle, so a large NUM_REGS maps onto FPGA block RAM instead of a wide reset fan-out.

## Interface
- DATA_W, 32: register width in bits.
- NUM_REGS, 32: number of registers, ≥2, need not be a power of two.
- ADDR_W, $clog2(NUM_REGS): address width. Derived; never overridden.
- NUM_RD, 2: number of read ports, 1..4.
- ZERO_REG, 1: when 1, register 0 reads 0 and writes to it are dropped.

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-low; sampled on posedge clk.
- RegWrite  in  1  write enable.
- WriteReg  in  ADDR_W  write address.
- WriteData  in  DATA_W  write data.
- rd_en  in  NUM_RD  per-port read enable; bit i belongs to port i.
- ReadReg  in  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- ReadData  out  NUM_RD*DATA_W  packed registered read data; port i uses bits [i*DATA_W +: DATA_W].
- ready  out  1  high once initialisation is complete.
- wr_drop  out  1  one-cycle pulse when an enabled write is discarded.

## Operation
- The state machine has two states, INIT and RUN.
- Any posedge with reset==0 does all of the following:
  - state←INIT, init_ptr←0;
  - ReadData←0, ready←0, wr_drop←0;
  - the array is not touched.
- In INIT, each posedge with reset==1:
  - writes 0 to Regs[init_ptr] and increments init_ptr;
  - when init_ptr==NUM_REGS-1, moves to RUN and sets ready←1.
- In INIT, all reads return 0 and ReadData is forced to 0.
- In INIT, an enabled write is discarded and wr_drop pulses.
- In RUN, a write with RegWrite=1 stores WriteData at WriteReg, except in these cases:
  - WriteReg ≥ NUM_REGS: discarded, wr_drop pulses;
  - WriteReg==0 with ZERO_REG=1: discarded silently, no wr_drop.
- Each read port in RUN with rd_en[i]=1 loads ReadData[i] on the edge, using the first matching rule:
  - ReadReg[i] ≥ NUM_REGS → 0;
  - ReadReg[i]==0 with ZERO_REG=1 → 0;
  - RegWrite=1 and WriteReg==ReadReg[i] and the write is accepted → WriteData (bypass);
  - otherwise → Regs[ReadReg[i]].
- When rd_en[i]=0, ReadData[i] holds its value.
- Ports are independent. Any number of ports may read the same address in the same cycle.
- With ZERO_REG=0, register 0 is an ordinary register.
- Data is never truncated or extended; all paths are DATA_W wide.

## Timing
- Read latency is 1 cycle: address and rd_en sampled at edge N appear on ReadData after edge N.
- Write-to-read distance:
  - write at edge N, read issued at edge N: returns the new data through the bypass;
  - read issued at edge N+1 or later: returns the new data from the array.
- ready timing:
  - the first posedge with reset==1 clears Regs[0];
  - ready is observed high after the NUM_REGS-th such edge;
  - the first accepted write occurs at edge NUM_REGS+1.
- Reset asserted mid-INIT: init_ptr restarts at 0 and the full NUM_REGS-cycle sequence repeats.
- Reset asserted in RUN: ready falls after that edge, and contents are re-cleared by the new INIT pass.
- wr_drop is registered, high for exactly the cycle after the offending edge.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Test plan
- Init and ready: hold reset=0 for 3 cycles, then release with NUM_REGS=32.
  - ready must rise after the 32nd edge.
  - A write of 0x55 at edge 31 must give wr_drop=1 and leave the register at 0.
  - Reading all 32 registers afterwards must return 0.
- Write then read: write 0xDEADBEEF to r8, then read r8 on port 0 and port 1 at the next edge.
  - Both ports must return 0xDEADBEEF one cycle later.
- Bypass: in one edge, write 0x1234 to r9 while port 0 reads r9 and port 1 reads r10 (holding 0x77).
  - Required: port 0 returns 0x1234, port 1 returns 0x77.
- Zero register:
  - ZERO_REG=1: write 0xFFFF to r0 while reading r0 → reads 0, wr_drop stays 0.
  - ZERO_REG=0: the same write is stored and read back as 0xFFFF.
- Out of range, with NUM_REGS=24, ADDR_W=5:
  - write to address 30 → wr_drop=1, nothing stored;
  - read of address 30 → 0.
- Reset mid-init: assert reset at INIT cycle 10, release after 1 cycle.
  - ready must appear exactly NUM_REGS edges after the release.
  - rd_en=0 must hold ReadData unchanged in RUN.
